pipe_stage_skid: RTL and testbench

//  Generic inter-stage pipeline register with a valid/ready handshake, flush and optional 2-entry skid buffer.

---
 rtl/cpu_pipe_pkg.sv | 25 ++
 rtl/pipe_entry_reg.sv | 45 ++++
 rtl/pipe_stage_skid.sv | 131 +++++++++++++
 tb/tb_pipe_stage_skid.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline-stage definitions: default widths, occupancy state encoding, ctrl-vector bit positions.
package cpu_pipe_pkg;

  localparam int unsigned DATA_W_DEF      = 96;
  localparam int unsigned CTRL_W_DEF      = 3;
  localparam int unsigned STALL_CNT_W_DEF = 16;

  // Payload widths as packed by each instantiating stage
  localparam int unsigned IF_ID_DATA_W  = 64;
  localparam int unsigned ID_EX_DATA_W  = 96;
  localparam int unsigned EX_MEM_DATA_W = 96;
  localparam int unsigned MEM_WB_DATA_W = 64;

  // Occupancy encoding doubles as the entry count reported on the occupancy port
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_e;

  localparam int unsigned CTRL_REGWRITE = 0;
  localparam int unsigned CTRL_LOWRITE  = 1;
  localparam int unsigned CTRL_HIWRITE  = 2;

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry (valid + ctrl + data). Kill clears valid/ctrl but keeps data; load captures data/ctrl.
module pipe_entry_reg
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              CLR,
  input  logic              i_clr_ctrl,
  input  logic              i_load,
  input  logic              i_valid_d,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;

  always_ff @(posedge clk) begin
    if (CLR) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ctrl  <= '0;
    end else if (i_clr_ctrl) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else begin
      r_valid <= i_valid_d;
      if (i_load) begin
        r_data <= i_data;
        r_ctrl <= i_ctrl;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_ctrl  = r_ctrl;

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage register with valid/ready, flush and optional 2-entry skid; 1-cycle latency, full throughput.
// SKID_EN=1: in_ready registered (!skid valid); SKID_EN=0: in_ready = !out_valid || out_ready.
module pipe_stage_skid
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned CTRL_W      = CTRL_W_DEF,
  parameter bit          SKID_EN     = 1'b1,
  parameter int unsigned STALL_CNT_W = STALL_CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   CLR,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [CTRL_W-1:0]      in_ctrl,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [1:0]             occupancy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  occ_state_e             r_state;
  occ_state_e             w_state_nxt;
  logic                   w_main_load;
  logic                   w_main_from_skid;
  logic                   w_main_v;
  logic                   w_skid_v;
  logic                   w_in_fire;
  logic                   w_out_fire;
  logic [DATA_W-1:0]      w_main_data;
  logic [CTRL_W-1:0]      w_main_ctrl;
  logic [DATA_W-1:0]      w_skid_data;
  logic [CTRL_W-1:0]      w_skid_ctrl;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  assign in_ready   = SKID_EN ? !w_skid_v : (!w_main_v || out_ready);
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = w_main_v && out_ready;

  always_ff @(posedge clk) begin
    if (CLR) r_state <= ST_EMPTY;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_main_load      = 1'b0;
    w_main_from_skid = 1'b0;
    unique case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_state_nxt = ST_ONE;
          w_main_load = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_main_load = 1'b1;
        end else if (w_in_fire && SKID_EN) begin
          w_state_nxt = ST_FULL;
        end else if (w_out_fire) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_out_fire) begin
          w_state_nxt      = ST_ONE;
          w_main_load      = 1'b1;
          w_main_from_skid = 1'b1;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
    // Flush discards everything, including a same-cycle input
    if (flush) w_state_nxt = ST_EMPTY;
  end

  pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk        (clk),
    .CLR        (CLR),
    .i_clr_ctrl (flush),
    .i_load     (w_main_load),
    .i_valid_d  (w_state_nxt != ST_EMPTY),
    .i_data     (w_main_from_skid ? w_skid_data : in_data),
    .i_ctrl     (w_main_from_skid ? w_skid_ctrl : in_ctrl),
    .o_valid    (w_main_v),
    .o_data     (w_main_data),
    .o_ctrl     (w_main_ctrl)
  );

  generate
    if (SKID_EN) begin : g_skid
      pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk        (clk),
        .CLR        (CLR),
        .i_clr_ctrl (flush),
        .i_load     ((r_state == ST_ONE) && (w_state_nxt == ST_FULL)),
        .i_valid_d  (w_state_nxt == ST_FULL),
        .i_data     (in_data),
        .i_ctrl     (in_ctrl),
        .o_valid    (w_skid_v),
        .o_data     (w_skid_data),
        .o_ctrl     (w_skid_ctrl)
      );
    end else begin : g_noskid
      assign w_skid_v    = 1'b0;
      assign w_skid_data = '0;
      assign w_skid_ctrl = '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (CLR) begin
      r_stall_cnt <= '0;
    end else if (w_main_v && !out_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    end
  end

  assign out_valid = w_main_v;
  assign out_data  = w_main_data;
  // Stale ctrl after a drain must not reach downstream write enables
  assign out_ctrl  = w_main_v ? w_main_ctrl : '0;
  assign occupancy = r_state;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench: skid instance, 4-bit-counter instance and no-skid instance, each with its own stimulus.
module tb_pipe_stage_skid;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // skid instance
  logic a_clr, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [15:0] a_in_data, a_out_data;
  logic [2:0]  a_in_ctrl, a_out_ctrl;
  logic [1:0]  a_occ;
  logic [15:0] a_stall;
  // saturation instance
  logic s_clr, s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [15:0] s_in_data, s_out_data;
  logic [2:0]  s_in_ctrl, s_out_ctrl;
  logic [1:0]  s_occ;
  logic [3:0]  s_stall;
  // no-skid instance
  logic n_clr, n_flush, n_in_valid, n_in_ready, n_out_valid, n_out_ready;
  logic [15:0] n_in_data, n_out_data;
  logic [2:0]  n_in_ctrl, n_out_ctrl;
  logic [1:0]  n_occ;
  logic [15:0] n_stall;

  pipe_stage_skid #(.DATA_W(16), .CTRL_W(3), .SKID_EN(1'b1), .STALL_CNT_W(16)) u_dut (
    .clk(clk), .CLR(a_clr), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_ctrl(a_in_ctrl), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_ctrl(a_out_ctrl), .occupancy(a_occ), .stall_cnt(a_stall));

  pipe_stage_skid #(.DATA_W(16), .CTRL_W(3), .SKID_EN(1'b1), .STALL_CNT_W(4)) u_sat (
    .clk(clk), .CLR(s_clr), .flush(s_flush), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .in_ctrl(s_in_ctrl), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_data(s_out_data), .out_ctrl(s_out_ctrl), .occupancy(s_occ), .stall_cnt(s_stall));

  pipe_stage_skid #(.DATA_W(16), .CTRL_W(3), .SKID_EN(1'b0), .STALL_CNT_W(16)) u_ns (
    .clk(clk), .CLR(n_clr), .flush(n_flush), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .in_data(n_in_data), .in_ctrl(n_in_ctrl), .out_valid(n_out_valid), .out_ready(n_out_ready),
    .out_data(n_out_data), .out_ctrl(n_out_ctrl), .occupancy(n_occ), .stall_cnt(n_stall));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // no-skid table: out_ready per cycle and hand-derived expectations
  bit       t_ordy [10] = '{1, 0, 1, 0, 1, 0, 1, 1, 1, 0};
  bit       t_irdy [10] = '{1, 0, 1, 0, 1, 0, 1, 1, 1, 0};
  bit       t_ov   [10] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
  int       t_od   [10] = '{0, 1, 1, 2, 2, 3, 3, 4, 5, 6};

  initial begin
    int pend;
    a_clr = 1; a_flush = 0; a_in_valid = 1; a_in_data = 16'h55; a_in_ctrl = 3'b111; a_out_ready = 0;
    s_clr = 1; s_flush = 0; s_in_valid = 0; s_in_data = 0; s_in_ctrl = 0; s_out_ready = 0;
    n_clr = 1; n_flush = 0; n_in_valid = 0; n_in_data = 0; n_in_ctrl = 0; n_out_ready = 0;

    // reset held two cycles with input offered
    step(); step();
    chk("rst_out_valid", 32'(a_out_valid), 0);
    chk("rst_out_ctrl",  32'(a_out_ctrl), 0);
    chk("rst_occ",       32'(a_occ), 0);
    chk("rst_stall",     32'(a_stall), 0);
    chk("rst_in_ready",  32'(a_in_ready), 1);
    a_clr = 0; s_clr = 0; n_clr = 0; a_in_valid = 0;
    step();
    chk("idle_out_valid", 32'(a_out_valid), 0);

    // streaming 1..8
    a_out_ready = 1;
    for (int k = 1; k <= 8; k++) begin
      a_in_valid = 1; a_in_data = 16'(k); a_in_ctrl = 3'b101;
      step();
      chk("stream_data",  32'(a_out_data), k);
      chk("stream_valid", 32'(a_out_valid), 1);
      chk("stream_ctrl",  32'(a_out_ctrl), 5);
    end
    a_in_valid = 0;
    step();
    chk("drain_valid", 32'(a_out_valid), 0);
    chk("drain_ctrl",  32'(a_out_ctrl), 0);
    chk("drain_occ",   32'(a_occ), 0);
    chk("drain_stall", 32'(a_stall), 0);

    // back-pressure A,B,C
    a_out_ready = 0; a_in_valid = 1; a_in_data = 16'h00A; a_in_ctrl = 3'b001;
    step();
    chk("bp_A_data", 32'(a_out_data), 16'h00A);
    a_in_data = 16'h00B;
    chk("bp_rdy_B", 32'(a_in_ready), 1);
    step();
    a_in_data = 16'h00C;
    chk("bp_full_rdy", 32'(a_in_ready), 0);
    chk("bp_full_occ", 32'(a_occ), 2);
    chk("bp_full_data", 32'(a_out_data), 16'h00A);
    step(); step();
    chk("bp_hold_stall", 32'(a_stall), 3);
    chk("bp_hold_data", 32'(a_out_data), 16'h00A);
    chk("bp_hold_occ", 32'(a_occ), 2);
    a_out_ready = 1;
    step();
    chk("bp_rel_B", 32'(a_out_data), 16'h00B);
    chk("bp_rel_occ", 32'(a_occ), 1);
    chk("bp_rel_rdy", 32'(a_in_ready), 1);
    step();
    chk("bp_rel_C", 32'(a_out_data), 16'h00C);
    a_in_valid = 0;
    step();
    chk("bp_end_occ", 32'(a_occ), 0);
    chk("bp_end_valid", 32'(a_out_valid), 0);
    chk("bp_end_stall", 32'(a_stall), 3);

    // flush while FULL with a same-cycle input
    a_out_ready = 0; a_in_valid = 1; a_in_data = 16'h00D; a_in_ctrl = 3'b010;
    step();
    a_in_data = 16'h00E;
    step();
    chk("fl_pre_occ", 32'(a_occ), 2);
    a_in_data = 16'h00F; a_in_ctrl = 3'b111; a_flush = 1;
    step();
    a_flush = 0;
    chk("fl_valid", 32'(a_out_valid), 0);
    chk("fl_ctrl",  32'(a_out_ctrl), 0);
    chk("fl_occ",   32'(a_occ), 0);
    chk("fl_rdy",   32'(a_in_ready), 1);
    chk("fl_stall", 32'(a_stall), 5);
    chk("fl_data_kept", 32'(a_out_data), 16'h00D);
    a_in_valid = 0; a_out_ready = 1;
    step();
    chk("fl_dropped", 32'(a_out_valid), 0);

    // reset mid-transfer
    a_out_ready = 0; a_in_valid = 1; a_in_data = 16'h0011;
    step();
    a_clr = 1; a_in_valid = 0;
    step();
    a_clr = 0;
    chk("clr_mid_occ", 32'(a_occ), 0);
    chk("clr_mid_stall", 32'(a_stall), 0);
    chk("clr_mid_valid", 32'(a_out_valid), 0);

    // saturation on 4-bit counter
    s_in_valid = 1; s_in_data = 16'h0033; s_in_ctrl = 3'b001;
    step();
    s_in_valid = 0;
    repeat (10) step();
    chk("sat_mid", 32'(s_stall), 10);
    repeat (10) step();
    chk("sat_end", 32'(s_stall), 15);
    chk("sat_valid", 32'(s_out_valid), 1);

    // no-skid: combinational in_ready, order kept
    pend = 1;
    n_in_valid = 1;
    for (int i = 0; i < 10; i++) begin
      n_out_ready = t_ordy[i];
      n_in_data = 16'(pend);
      #1;
      chk("ns_in_ready", 32'(n_in_ready), 32'(t_irdy[i]));
      chk("ns_out_valid", 32'(n_out_valid), 32'(t_ov[i]));
      if (t_ov[i]) chk("ns_out_data", 32'(n_out_data), t_od[i]);
      step();
      if (t_irdy[i]) pend++;
    end
    n_in_valid = 0;
    chk("ns_stall", 32'(n_stall), 4);
    chk("ns_occ", 32'(n_occ), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
